// File: rtl/bounce_pkg.sv
// bounce_pkg
//   Shared types for the bounce counter slice.
//   mode_t : run-time counting mode, encoded to match the 2-bit mode port.
//   dir_t  : travel direction; this is also the state of the direction FSM
//            held in bounce_counter and exposed on its dir output.
package bounce_pkg;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    BOUNCE    = 2'b10,
    HOLD      = 2'b11
  } mode_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage : bounce_pkg

// File: rtl/bounce_step_calc.sv
// bounce_step_calc
//   Purely combinational next-state logic for bounce_counter. Given the
//   current count, direction, mode and step it produces the value the
//   register block should take on an enabled, non-loading cycle.
//
//   Parameters : WIDTH, MIN_VAL, MAX_VAL (inclusive bounds)
//   Inputs     : cnt   current registered count
//                dir   current direction (FSM state)
//                mode  counting mode
//                step  step magnitude, 0 is treated as 1
//   Outputs    : cnt_nxt   next count
//                dir_nxt   next direction
//                wrap_evt  a wrap happens on this step (wrap modes only)
//                turn_evt  a bound reversal happens on this step (BOUNCE)
//                oor       cnt lies outside [MIN_VAL, MAX_VAL]
//
//   In HOLD the outputs simply echo the current state. When cnt is out of
//   range (and mode is not HOLD) the outputs describe the recovery move
//   and no event is flagged.
module bounce_step_calc
  import bounce_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 6
) (
  input  logic [WIDTH-1:0] cnt,
  input  dir_t             dir,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] cnt_nxt,
  output dir_t             dir_nxt,
  output logic             wrap_evt,
  output logic             turn_evt,
  output logic             oor
);

  // One guard bit on every sum and difference: a sum can reach
  // 2*(2**WIDTH-1) and a difference can go negative, and neither may
  // alias back into the legal range.
  localparam int XW = WIDTH + 1;

  localparam logic [XW-1:0]    MIN_X = XW'(MIN_VAL);
  localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [XW-1:0] cnt_x;
  logic [XW-1:0] step_x;
  logic [XW-1:0] sum_x;
  logic [XW-1:0] diff_x;

  logic above;
  logic below;
  logic up_over;     // cnt+s >  MAX : wraps in UP_WRAP
  logic up_reach;    // cnt+s >= MAX : clamps and turns in BOUNCE
  logic down_under;  // cnt-s <  MIN : wraps in DOWN_WRAP
  logic down_reach;  // cnt-s <= MIN : clamps and turns in BOUNCE

  assign cnt_x  = {1'b0, cnt};
  assign step_x = (step == '0) ? XW'(1) : {1'b0, step};
  assign sum_x  = cnt_x + step_x;
  assign diff_x = cnt_x - step_x;

  assign above = (cnt_x > MAX_X);
  assign below = (cnt_x < MIN_X);
  assign oor   = above | below;

  assign up_over  = (sum_x > MAX_X);
  assign up_reach = (sum_x >= MAX_X);

  // A borrow out of the subtraction sets the guard bit; that alone means
  // the result is below any MIN_VAL >= 0.
  assign down_under = diff_x[WIDTH] | (diff_x < MIN_X);
  assign down_reach = diff_x[WIDTH] | (diff_x <= MIN_X);

  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    wrap_evt = 1'b0;
    turn_evt = 1'b0;

    if (mode == HOLD) begin
      // Frozen: no motion and no recovery.
      cnt_nxt = cnt;
    end else if (above) begin
      // Recovery from above: park on the top bound heading down.
      cnt_nxt = MAX_W;
      dir_nxt = DOWN;
    end else if (below) begin
      // Recovery from below: park on the bottom bound heading up.
      cnt_nxt = MIN_W;
      dir_nxt = UP;
    end else begin
      case (mode)
        UP_WRAP: begin
          dir_nxt = UP;
          if (up_over) begin
            // Remainder past MAX is discarded, not carried into the wrap.
            cnt_nxt  = MIN_W;
            wrap_evt = 1'b1;
          end else begin
            cnt_nxt = sum_x[WIDTH-1:0];
          end
        end

        DOWN_WRAP: begin
          dir_nxt = DOWN;
          if (down_under) begin
            cnt_nxt  = MAX_W;
            wrap_evt = 1'b1;
          end else begin
            cnt_nxt = diff_x[WIDTH-1:0];
          end
        end

        default: begin
          // BOUNCE keeps whatever direction is current, so entering it
          // from a wrap mode continues the same way.
          if (dir == UP) begin
            if (up_reach) begin
              cnt_nxt  = MAX_W;
              dir_nxt  = DOWN;
              turn_evt = 1'b1;
            end else begin
              cnt_nxt = sum_x[WIDTH-1:0];
            end
          end else begin
            if (down_reach) begin
              cnt_nxt  = MIN_W;
              dir_nxt  = UP;
              turn_evt = 1'b1;
            end else begin
              cnt_nxt = diff_x[WIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

endmodule : bounce_step_calc

// File: rtl/bounce_counter.sv
// bounce_counter
//   Up/down/bounce counter with programmable inclusive range, step size,
//   run-time mode, synchronous load and out-of-range recovery. This block
//   owns the registers (cnt, direction FSM, wrap/turn pulses); the next
//   value comes from bounce_step_calc.
//
//   Parameters : WIDTH (bits), MIN_VAL, MAX_VAL (inclusive bounds)
//   Ports      : clk       rising-edge clock
//                rst       synchronous, active-high reset
//                en        advance the count this cycle
//                mode      00 UP_WRAP, 01 DOWN_WRAP, 10 BOUNCE, 11 HOLD
//                step      step magnitude (0 acts as 1)
//                load      load load_val into cnt (beats en and recovery)
//                load_val  value to load, any value including out of range
//                cnt       registered count
//                dir       registered direction, 0 UP / 1 DOWN (FSM state)
//                wrap      one-cycle pulse, wrap in a wrap mode
//                turn      one-cycle pulse, reversal at a bound in BOUNCE
//                at_min    cnt == MIN_VAL (combinational)
//                at_max    cnt == MAX_VAL (combinational)
//
//   Control interface: there is no valid/ready handshake. en is a plain
//   per-cycle qualifier that may toggle freely; en high on every cycle
//   gives one step per clock. load is likewise a single-cycle command.
module bounce_counter
  import bounce_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             wrap,
  output logic             turn,
  output logic             at_min,
  output logic             at_max
);

  // Range legality is checked once at elaboration.
  if (!((MIN_VAL >= 0) && (MIN_VAL < MAX_VAL) &&
        (MAX_VAL <= (2 ** WIDTH) - 1))) begin : g_param_check
    $error("bounce_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Registered state
  logic [WIDTH-1:0] cnt_q;
  dir_t             dir_q;
  logic             wrap_q;
  logic             turn_q;

  // Next state
  logic [WIDTH-1:0] cnt_d;
  dir_t             dir_d;
  logic             wrap_d;
  logic             turn_d;

  // Step calculator results
  logic [WIDTH-1:0] calc_cnt;
  dir_t             calc_dir;
  logic             calc_wrap;
  logic             calc_turn;
  logic             calc_oor;

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  bounce_step_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_step_calc (
    .cnt      (cnt_q),
    .dir      (dir_q),
    .mode     (mode_e),
    .step     (step),
    .cnt_nxt  (calc_cnt),
    .dir_nxt  (calc_dir),
    .wrap_evt (calc_wrap),
    .turn_evt (calc_turn),
    .oor      (calc_oor)
  );

  // Next-state process: load > recovery/step (both via the calculator) >
  // hold. Pulses default low so they can never stretch past one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    turn_d = 1'b0;

    if (load) begin
      // Direction untouched and no pulse on a load.
      cnt_d = load_val;
    end else if (en) begin
      cnt_d  = calc_cnt;
      dir_d  = calc_dir;
      // A recovery cycle is never an event, even if the calculator's
      // event terms were to misfire.
      wrap_d = calc_wrap & ~calc_oor;
      turn_d = calc_turn & ~calc_oor & ~calc_wrap;
    end
  end

  // State register process
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= MIN_W;
      dir_q  <= UP;
      wrap_q <= 1'b0;
      turn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      turn_q <= turn_d;
    end
  end

  assign cnt    = cnt_q;
  assign dir    = dir_q;
  assign wrap   = wrap_q;
  assign turn   = turn_q;
  assign at_min = (cnt_q == MIN_W);
  assign at_max = (cnt_q == MAX_W);

endmodule : bounce_counter

// File: tb/tb_bounce_counter.sv
// tb_bounce_counter
//   Directed bench for bounce_counter at WIDTH=3, MIN_VAL=1, MAX_VAL=6.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   that same point, i.e. after the edge has settled.
module tb_bounce_counter;
  import bounce_pkg::*;

  localparam int W = 3;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         dir;
  logic         wrap;
  logic         turn;
  logic         at_min;
  logic         at_max;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected count sequence for the sweep tests
  logic [W-1:0] exp_q[$];

  bounce_counter #(
    .WIDTH   (3),
    .MIN_VAL (1),
    .MAX_VAL (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .dir      (dir),
    .wrap     (wrap),
    .turn     (turn),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    mode = UP_WRAP; step = 3'd1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cnt !== 3'd1) begin bad++; $display("FAIL reset_cnt got=%0d want=1", cnt); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%0b want=0", dir); end
    total++; if ({wrap, turn} !== 2'b00) begin bad++; $display("FAIL reset_pulse got=%b want=00", {wrap, turn}); end
    total++; if ({at_min, at_max} !== 2'b10) begin bad++; $display("FAIL reset_flags got=%b want=10", {at_min, at_max}); end
  endtask

  task automatic test_bounce_step1();
    logic [W-1:0] e_cnt;
    logic e_dir, e_turn;
    do_reset();
    mode = BOUNCE; step = 3'd1; en = 1'b1;
    exp_q = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2};
    for (int i = 0; i < 11; i++) begin
      tick();
      e_cnt  = exp_q.pop_front();
      e_turn = (i == 4) || (i == 9);
      e_dir  = (i >= 4) && (i < 9);
      total++; if (cnt !== e_cnt) begin bad++; $display("FAIL b1_cnt[%0d] got=%0d want=%0d", i, cnt, e_cnt); end
      total++; if (dir !== e_dir) begin bad++; $display("FAIL b1_dir[%0d] got=%0b want=%0b", i, dir, e_dir); end
      total++; if ({wrap, turn} !== {1'b0, e_turn}) begin bad++; $display("FAIL b1_pulse[%0d] got=%b want=%b", i, {wrap, turn}, {1'b0, e_turn}); end
      total++; if ({at_min, at_max} !== {e_cnt == 3'd1, e_cnt == 3'd6}) begin bad++; $display("FAIL b1_flags[%0d] got=%b", i, {at_min, at_max}); end
    end
  endtask

  task automatic test_bounce_step4();
    logic [W-1:0] e_cnt;
    logic e_dir, e_turn;
    do_reset();
    mode = BOUNCE; step = 3'd4; en = 1'b1;
    exp_q = {3'd5, 3'd6, 3'd2, 3'd1, 3'd5};
    for (int i = 0; i < 5; i++) begin
      tick();
      e_cnt  = exp_q.pop_front();
      e_turn = (i == 1) || (i == 3);
      e_dir  = (i == 1) || (i == 2);
      total++; if (cnt !== e_cnt) begin bad++; $display("FAIL b4_cnt[%0d] got=%0d want=%0d", i, cnt, e_cnt); end
      total++; if (dir !== e_dir) begin bad++; $display("FAIL b4_dir[%0d] got=%0b want=%0b", i, dir, e_dir); end
      total++; if ({wrap, turn} !== {1'b0, e_turn}) begin bad++; $display("FAIL b4_pulse[%0d] got=%b want=%b", i, {wrap, turn}, {1'b0, e_turn}); end
    end
  endtask

  task automatic test_wrap_modes();
    do_reset();
    do_load(3'd5);
    mode = UP_WRAP; step = 3'd1; en = 1'b1;
    tick();
    total++; if ({cnt, wrap} !== {3'd6, 1'b0}) begin bad++; $display("FAIL upw_6 got=%0d/%0b want=6/0", cnt, wrap); end
    tick();
    total++; if ({cnt, wrap, dir} !== {3'd1, 1'b1, 1'b0}) begin bad++; $display("FAIL upw_wrap got=%0d/%0b/%0b want=1/1/0", cnt, wrap, dir); end
    mode = DOWN_WRAP;
    tick();
    total++; if ({cnt, wrap, dir} !== {3'd6, 1'b1, 1'b1}) begin bad++; $display("FAIL dnw_wrap got=%0d/%0b/%0b want=6/1/1", cnt, wrap, dir); end
    tick();
    total++; if ({cnt, wrap, dir} !== {3'd5, 1'b0, 1'b1}) begin bad++; $display("FAIL dnw_5 got=%0d/%0b/%0b want=5/0/1", cnt, wrap, dir); end
    tick();
    total++; if ({cnt, wrap, turn} !== {3'd4, 1'b0, 1'b0}) begin bad++; $display("FAIL dnw_4 got=%0d/%0b/%0b want=4/0/0", cnt, wrap, turn); end
    // Large steps: 1+7=8 must wrap (not alias to 0), 6-7 must wrap to 6
    mode = UP_WRAP; step = 3'd7; do_load(3'd1); en = 1'b1;
    tick();
    total++; if ({cnt, wrap} !== {3'd1, 1'b1}) begin bad++; $display("FAIL upw_big got=%0d/%0b want=1/1", cnt, wrap); end
    mode = DOWN_WRAP; do_load(3'd6); en = 1'b1;
    tick();
    total++; if ({cnt, wrap} !== {3'd6, 1'b1}) begin bad++; $display("FAIL dnw_big got=%0d/%0b want=6/1", cnt, wrap); end
  endtask

  task automatic test_load_recovery();
    do_reset();
    do_load(3'd7);
    total++; if ({cnt, at_min, at_max} !== {3'd7, 1'b0, 1'b0}) begin bad++; $display("FAIL load7 got=%0d/%b want=7/00", cnt, {at_min, at_max}); end
    mode = BOUNCE; step = 3'd1; en = 1'b1;
    tick();
    total++; if ({cnt, dir, wrap, turn} !== {3'd6, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL rec_hi got=%0d/%0b/%b want=6/1/00", cnt, dir, {wrap, turn}); end
    tick();
    total++; if ({cnt, dir} !== {3'd5, 1'b1}) begin bad++; $display("FAIL rec_hi_next got=%0d/%0b want=5/1", cnt, dir); end
    do_load(3'd0);
    en = 1'b1;
    tick();
    total++; if ({cnt, dir, wrap, turn} !== {3'd1, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL rec_lo got=%0d/%0b/%b want=1/0/00", cnt, dir, {wrap, turn}); end
  endtask

  task automatic test_priority();
    do_reset();
    mode = DOWN_WRAP; step = 3'd1; en = 1'b1;
    tick();
    total++; if ({cnt, dir} !== {3'd6, 1'b1}) begin bad++; $display("FAIL pri_setup got=%0d/%0b want=6/1", cnt, dir); end
    load = 1'b1; load_val = 3'd4;
    tick();
    load = 1'b0;
    total++; if ({cnt, dir, wrap, turn} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL pri_load got=%0d/%0b/%b want=4/1/00", cnt, dir, {wrap, turn}); end
    rst = 1'b1; load = 1'b1; load_val = 3'd2;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    total++; if ({cnt, dir} !== {3'd1, 1'b0}) begin bad++; $display("FAIL pri_rst got=%0d/%0b want=1/0", cnt, dir); end
  endtask

  task automatic test_hold();
    do_reset();
    mode = BOUNCE; step = 3'd2; en = 1'b1;
    tick(); tick(); tick();  // 3, 5, 6(turn) -> dir DOWN
    total++; if ({cnt, dir} !== {3'd6, 1'b1}) begin bad++; $display("FAIL hold_setup got=%0d/%0b want=6/1", cnt, dir); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({cnt, dir, wrap, turn} !== {3'd6, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL hold_en0[%0d] got=%0d/%0b/%b", i, cnt, dir, {wrap, turn}); end
    end
    en = 1'b1; mode = HOLD;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({cnt, dir, wrap, turn} !== {3'd6, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL hold_mode[%0d] got=%0d/%0b/%b", i, cnt, dir, {wrap, turn}); end
    end
    // HOLD does not recover an out-of-range count
    do_load(3'd7);
    en = 1'b1;
    tick();
    total++; if ({cnt, dir} !== {3'd7, 1'b1}) begin bad++; $display("FAIL hold_oor got=%0d/%0b want=7/1", cnt, dir); end
  endtask

  task automatic test_step_zero();
    do_reset();
    mode = UP_WRAP; step = 3'd0; en = 1'b1;
    tick();
    total++; if (cnt !== 3'd2) begin bad++; $display("FAIL step0_a got=%0d want=2", cnt); end
    tick();
    total++; if ({cnt, wrap} !== {3'd3, 1'b0}) begin bad++; $display("FAIL step0_b got=%0d/%0b want=3/0", cnt, wrap); end
  endtask

  initial begin
    test_reset();
    test_bounce_step1();
    test_bounce_step4();
    test_wrap_modes();
    test_load_recovery();
    test_priority();
    test_hold();
    test_step_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bounce_counter

// File: doc/bounce_counter.md
# bounce_counter

Parametrised up/down/bounce counter with a programmable range, step size, run-time mode, synchronous load and out-of-range recovery. It is the general-purpose successor to the fixed 3-bit up/down sequencer. It sits in datapath control wherever a sweeping or wrapping index is needed: scan addresses, PWM ramps and test-pattern generation.

## Interface
- `WIDTH`, 3, counter width in bits
- `MIN_VAL`, 1, lower bound (inclusive); require 0 ≤ MIN_VAL < MAX_VAL
- `MAX_VAL`, 6, upper bound (inclusive); require MAX_VAL ≤ 2**WIDTH-1
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  advance the count this cycle
- `mode`  in  2  00 UP_WRAP, 01 DOWN_WRAP, 10 BOUNCE, 11 HOLD
- `step`  in  WIDTH  increment magnitude; a value of 0 is treated as 1
- `load`  in  1  load `load_val` into `cnt`
- `load_val`  in  WIDTH  value to load; any value is accepted, including out-of-range values
- `cnt`  out  WIDTH  current count (registered)
- `dir`  out  1  current direction, 0 = UP, 1 = DOWN (registered)
- `wrap`  out  1  one-cycle pulse: a wrap occurred in UP_WRAP or DOWN_WRAP
- `turn`  out  1  one-cycle pulse: a direction reversal occurred at a bound in BOUNCE
- `at_min`, `at_max`  out  1  combinational from `cnt`: `cnt==MIN_VAL` and `cnt==MAX_VAL` respectively

## Operation
- **Priority:** `rst` > `load` > out-of-range recovery > normal step.
- **Reset values:** `cnt`=MIN_VAL, `dir`=UP, `wrap`=0, `turn`=0.
- **Load:** `cnt`←`load_val` regardless of `en` or `mode`. `dir` is unchanged and no pulses are generated.
- **Recovery** (`en`=1, mode ≠ HOLD, `cnt` outside [MIN_VAL, MAX_VAL]):
  - `cnt`>MAX_VAL → `cnt`←MAX_VAL, `dir`←DOWN
  - `cnt`<MIN_VAL → `cnt`←MIN_VAL, `dir`←UP
  - No other motion happens that cycle, and no pulses are generated.
- **Step arithmetic:** all next-value sums and differences are computed in WIDTH+1 bits (unsigned), so overflow and underflow cannot alias into range. The effective step is s = (`step`==0) ? 1 : `step`.
- **UP_WRAP:** `dir`←UP.
  - If `cnt`+s > MAX_VAL: `cnt`←MIN_VAL and `wrap` pulses. The remainder is discarded.
  - Otherwise `cnt`←`cnt`+s.
- **DOWN_WRAP:** `dir`←DOWN.
  - If `cnt`−s < MIN_VAL: `cnt`←MAX_VAL and `wrap` pulses.
  - Otherwise `cnt`←`cnt`−s.
- **BOUNCE, `dir`=UP:**
  - If `cnt`+s ≥ MAX_VAL: `cnt`←MAX_VAL (clamped), `dir`←DOWN, `turn` pulses.
  - Otherwise `cnt`←`cnt`+s.
- **BOUNCE, `dir`=DOWN:** symmetric to the UP case, using MIN_VAL; on reaching it `dir`←UP and `turn` pulses.
- **HOLD, or `en`=0:** `cnt` and `dir` hold; `wrap`=`turn`=0.
- **Mode changes:** `mode` is sampled every enabled cycle and takes effect on that same edge. Switching from a wrap mode into BOUNCE continues in the current `dir`.
- **Pulse width:** `wrap` and `turn` are never asserted together, and neither lasts more than one cycle per event.

## Timing
- Latency is one cycle: inputs sampled at edge N are reflected in `cnt`, `dir`, `wrap` and `turn` after edge N.
- A pulse is coincident with the new `cnt` value (for example, `turn`=1 in the cycle where `cnt` first shows MAX_VAL).
- `at_min` and `at_max` are combinational from registered `cnt`; there is no added latency.
- Reset mid-count takes effect at the next edge, even if `load` or `en` is asserted.
- `en` has no handshake and may toggle every cycle. A 100% duty cycle gives one step per clock.

## Structure
- Shared package `bounce_pkg`:
  - `mode_t` enum (UP_WRAP, DOWN_WRAP, BOUNCE, HOLD)
  - `dir_t` enum (UP, DOWN)
- The register block is the top module `bounce_counter`. It holds `cnt`, `dir`, `wrap` and `turn`, and the two-state `dir_t` FSM.
- One sub-module, `bounce_step_calc`, holds the purely combinational next-state logic:
  - inputs: `cnt`, `dir`, `mode`, `step`
  - outputs: next `cnt`, next `dir`, `wrap_evt`, `turn_evt`, `oor`
  - contains the WIDTH+1-bit arithmetic and the bound checks
- Parameter legality is checked at elaboration (assertion on the MIN/MAX/WIDTH constraints).

## Test plan
All scenarios use the defaults (WIDTH=3, MIN=1, MAX=6) unless stated.
- **Reset, BOUNCE, step=1, en=1:** `cnt` runs 1,2,3,4,5,6,5,4,3,2,1,2 → `turn`=1 exactly at the first 6 and the later 1; `dir` flips on those cycles.
- **BOUNCE, step=4, from reset:** `cnt` runs 1,5,6,2,1,5 → 6 is clamped with `turn`; 1 is clamped with `turn`; no value outside [1,6].
- **UP_WRAP step=1, then DOWN_WRAP:** 5,6,1 (`wrap` on 1); then switch mode → 6 (`wrap`), 5,4; `dir`=DOWN after the switch.
- **Load 7, then en=1:** `cnt`=7 → next `cnt`=6, `dir`=DOWN, no pulse, then 5. Load 0 → next 1, `dir`=UP.
- **Priority:** `load`=1 with `en`=1 → `cnt`=`load_val`, no step taken. `rst`=1 with `load`=1 at `cnt`=4 → `cnt`=1, `dir`=UP.
- **Hold conditions:** `en`=0 or mode=HOLD for 5 cycles → `cnt` and `dir` are frozen with no pulses. `step`=0 in UP_WRAP → advances by 1.
